pdm_capture_ctrl: RTL and testbench
===================================

Name: pdm_capture_ctrl

Overview:
- Capture sequencer between the PDM/CIC/FIR PCM output and the 8-bit readout FIFO drained over SPI.
- Decodes byte commands from the SPI slave (START with length, STOP, CLEAR).
- Gates the microphone clock and discards a warm-up window of samples.
- Serialises each 16-bit PCM sample into two FIFO bytes, MSB first, and counts captured samples; reports status and overflow.

Parameters:
- WARMUP_SAMPLES, 1024: PCM samples discarded after mic_en rises; 0 skips warm-up.
- LEN_WIDTH, 16: width of capture length and sample counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  one-cycle strobe, command byte from SPI slave
- cmd_data  in  8  command/operand byte
- pcm_valid  in  1  one-cycle strobe, new PCM sample
- pcm_data  in  16  signed PCM sample
- fifo_full  in  1  FIFO cannot accept a byte this cycle
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  8  FIFO write byte
- fifo_flush  out  1  one-cycle FIFO clear pulse
- mic_en  out  1  enables M_CLK generation
- busy  out  1  high in WARMUP or CAPTURE
- overflow  out  1  sticky: sample dropped
- status  out  8  {busy, overflow, state[1:0], done, 3'b000}

Behaviour:
- Reset: all outputs 0; state IDLE; parser at OP; counters, length and pending byte cleared. A reset mid-capture discards any pending LSB.
- Command parser, states OP / LEN_HI / LEN_LO; advances only on cmd_valid.
  - 0xA1 START: consume two operand bytes, length = {hi, lo}. Action fires on the cycle LEN_LO is consumed.
  - 0xA2 STOP: single byte.
  - 0xA3 CLEAR: single byte.
  - Any other opcode is ignored; parser stays in OP.
- START in IDLE or DONE:
  - Load length, clear counter and done; mic_en=1.
  - Next state WARMUP, or CAPTURE if WARMUP_SAMPLES==0.
  - START while busy: operands consumed, command ignored.
  - length=0 means continuous capture until STOP.
- WARMUP: count pcm_valid pulses and write nothing. After WARMUP_SAMPLES pulses go to CAPTURE. The sample that completes the count is not captured.
- CAPTURE, for a sample accepted at cycle t:
  - Accept condition: pcm_valid=1, no LSB pending, fifo_full=0.
  - t+1: fifo_wr_en=1 with pcm_data[15:8].
  - t+2: fifo_wr_en=1 with pcm_data[7:0], if fifo_full=0 that cycle; otherwise hold the LSB pending and write it on the first cycle fifo_full=0.
  - Counter increments on the MSB write.
- Overflow: pcm_valid while fifo_full=1 or while an LSB is pending drops the whole sample (no byte written, no count). overflow is set sticky.
- Length reached (counter==length, length≠0): after the LSB of the last sample is written → DONE. In DONE: mic_en=0, done=1, busy=0.
- STOP:
  - In WARMUP: IDLE next cycle, mic_en=0.
  - In CAPTURE: finish the pending MSB/LSB pair first, then IDLE; done stays 0.
  - In IDLE/DONE: ignored.
- CLEAR:
  - Honoured only in IDLE/DONE: fifo_flush pulses one cycle, overflow and done cleared, state IDLE.
  - While busy it is ignored.
- Simultaneous cmd_valid and pcm_valid: both are processed in the same cycle. A STOP decoded at cycle t does not block a sample accepted at t; that sample completes before IDLE.
- fifo_wr_en is never asserted when fifo_full=1.
- status state encoding: IDLE=00, WARMUP=01, CAPTURE=10, DONE=11.

Test Plan:
- WARMUP_SAMPLES=4. Send A1 00 03. Then 7 pcm_valid with samples 0x0001..0x0007 → mic_en=1; bytes 00 05 00 06 00 07 written; state DONE; mic_en=0; status=0x38.
- In CAPTURE, pcm_valid 0x1234 with fifo_full asserted at t+2 for 3 cycles → 0x12 at t+1, 0x34 at t+5; a pcm_valid at t+3 is dropped and overflow=1.
- A1 00 00 (continuous), 10 samples, then A2 issued while an LSB is pending → the LSB is written, then IDLE; 20 bytes total; done=0.
- A3 while busy → no fifo_flush. A3 in DONE with overflow=1 → one-cycle fifo_flush, overflow=0, status=0x00.
- Opcode 0x55, then A1 00 02 → 0x55 ignored; capture of 2 samples proceeds normally.
- rst asserted for 1 cycle mid-CAPTURE with an LSB pending → next cycle all outputs 0, no further FIFO writes; a subsequent A1 00 01 works normally.

Source files
------------

// File: rtl/pdm_capture_ctrl.sv
// PDM capture sequencer: decodes SPI byte commands, gates the mic clock, drops a
// warm-up window and packs 16-bit PCM samples into MSB/LSB FIFO byte pairs.
//
// state   | meaning
// IDLE    | mic off, waiting for START
// WARMUP  | mic on, discarding WARMUP_SAMPLES samples
// CAPTURE | mic on, writing samples to the FIFO
// DONE    | length reached, mic off, done flag set
module pdm_capture_ctrl #(
  parameter int WARMUP_SAMPLES = 1024,
  parameter int LEN_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  input  logic        pcm_valid,
  input  logic [15:0] pcm_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  output logic        fifo_flush,
  output logic        mic_en,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  status
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WARMUP  = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    P_OP     = 2'b00,
    P_LEN_HI = 2'b01,
    P_LEN_LO = 2'b10
  } parse_e;

  localparam int WW = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam logic [WW-1:0] WARM_LOAD = (WARMUP_SAMPLES > 0) ? WW'(WARMUP_SAMPLES - 1) : '0;

  state_e               state_q, state_d;
  parse_e               parse_q, parse_d;
  logic [7:0]           len_hi_q, len_hi_d;
  logic [LEN_WIDTH-1:0] length_q, length_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [WW-1:0]        warm_q, warm_d;
  logic [7:0]           msb_q, msb_d;
  logic [7:0]           lsb_q, lsb_d;
  logic                 msb_pend_q, msb_pend_d;
  logic                 lsb_pend_q, lsb_pend_d;
  logic                 stop_q, stop_d;
  logic                 ovf_q, ovf_d;
  logic                 flush_q, flush_d;

  logic                 start_cmd, stop_cmd, clear_cmd;
  logic [LEN_WIDTH-1:0] start_len;
  logic                 wr_en, pair_busy, len_hit, cap_open, accept;

  always_comb begin
    state_d    = state_q;
    parse_d    = parse_q;
    len_hi_d   = len_hi_q;
    length_d   = length_q;
    count_d    = count_q;
    warm_d     = warm_q;
    msb_d      = msb_q;
    lsb_d      = lsb_q;
    msb_pend_d = msb_pend_q;
    lsb_pend_d = lsb_pend_q;
    stop_d     = stop_q;
    ovf_d      = ovf_q;
    flush_d    = 1'b0;
    start_cmd  = 1'b0;
    stop_cmd   = 1'b0;
    clear_cmd  = 1'b0;
    start_len  = LEN_WIDTH'({len_hi_q, cmd_data});

    if (cmd_valid) begin
      case (parse_q)
        P_OP: begin
          case (cmd_data)
            8'hA1:   parse_d = P_LEN_HI;
            8'hA2:   stop_cmd = 1'b1;
            8'hA3:   clear_cmd = 1'b1;
            default: ;
          endcase
        end
        P_LEN_HI: begin
          len_hi_d = cmd_data;
          parse_d  = P_LEN_LO;
        end
        P_LEN_LO: begin
          start_cmd = 1'b1;
          parse_d   = P_OP;
        end
        default: parse_d = P_OP;
      endcase
    end

    // Byte pair: MSB then LSB, each held while the FIFO is full.
    pair_busy = msb_pend_q | lsb_pend_q;
    wr_en     = pair_busy & ~fifo_full;
    if (wr_en && msb_pend_q) begin
      msb_pend_d = 1'b0;
      lsb_pend_d = 1'b1;
      count_d    = count_q + LEN_WIDTH'(1);
    end else if (wr_en) begin
      lsb_pend_d = 1'b0;
    end

    len_hit  = (length_q != '0) && (count_q == length_q);
    cap_open = (state_q == ST_CAPTURE) && !stop_q && !len_hit;
    accept   = cap_open && pcm_valid && !pair_busy && !fifo_full;
    if (cap_open && pcm_valid && (pair_busy || fifo_full)) ovf_d = 1'b1;
    if (accept) begin
      msb_pend_d = 1'b1;
      msb_d      = pcm_data[15:8];
      lsb_d      = pcm_data[7:0];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_cmd) begin
          length_d = start_len;
          count_d  = '0;
          stop_d   = 1'b0;
          warm_d   = WARM_LOAD;
          state_d  = (WARMUP_SAMPLES == 0) ? ST_CAPTURE : ST_WARMUP;
        end else if (clear_cmd) begin
          flush_d = 1'b1;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (stop_cmd) begin
          state_d = ST_IDLE;
        end else if (pcm_valid) begin
          if (warm_q == '0) state_d = ST_CAPTURE;
          else              warm_d  = warm_q - WW'(1);
        end
      end
      ST_CAPTURE: begin
        if (stop_cmd) stop_d = 1'b1;
        // Leave only once no byte of the current pair is outstanding.
        if (!pair_busy && !accept) begin
          if (len_hit) begin
            state_d = ST_DONE;
          end else if (stop_q || stop_cmd) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      parse_q    <= P_OP;
      len_hi_q   <= '0;
      length_q   <= '0;
      count_q    <= '0;
      warm_q     <= '0;
      msb_q      <= '0;
      lsb_q      <= '0;
      msb_pend_q <= 1'b0;
      lsb_pend_q <= 1'b0;
      stop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      parse_q    <= parse_d;
      len_hi_q   <= len_hi_d;
      length_q   <= length_d;
      count_q    <= count_d;
      warm_q     <= warm_d;
      msb_q      <= msb_d;
      lsb_q      <= lsb_d;
      msb_pend_q <= msb_pend_d;
      lsb_pend_q <= lsb_pend_d;
      stop_q     <= stop_d;
      ovf_q      <= ovf_d;
      flush_q    <= flush_d;
    end
  end

  assign fifo_wr_en   = wr_en;
  assign fifo_wr_data = msb_pend_q ? msb_q : (lsb_pend_q ? lsb_q : 8'h00);
  assign fifo_flush   = flush_q;
  assign mic_en       = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE);
  assign busy         = mic_en;
  assign overflow     = ovf_q;
  assign status       = {busy, ovf_q, state_q, (state_q == ST_DONE), 3'b000};

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl with a 4-sample warm-up window.
module tb_pdm_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        pcm_valid;
  logic [15:0] pcm_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_flush;
  logic        mic_en;
  logic        busy;
  logic        overflow;
  logic [7:0]  status;

  int tests = 0;
  int fails = 0;
  int cnum  = 0;
  int viol  = 0;
  int nflush = 0;
  logic [7:0] wlog[$];
  int         wcyc[$];

  pdm_capture_ctrl #(.WARMUP_SAMPLES(4), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .pcm_valid(pcm_valid), .pcm_data(pcm_data), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_flush(fifo_flush),
    .mic_en(mic_en), .busy(busy), .overflow(overflow), .status(status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnum <= cnum + 1;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wlog.push_back(fifo_wr_data);
      wcyc.push_back(cnum);
      if (fifo_full) viol++;
    end
    if (fifo_flush) nflush++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic cv, input logic [7:0] cd, input logic pv,
                     input logic [15:0] pd, input logic ff);
    cmd_valid = cv;
    cmd_data  = cd;
    pcm_valid = pv;
    pcm_data  = pd;
    fifo_full = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic pcm(input logic [15:0] d);
    cyc(1'b0, 8'h00, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic warmup();
    for (int i = 0; i < 4; i++) begin
      pcm(16'hFFFF);
      idle(1);
    end
  endtask

  int t0;
  int nb;
  int fl0;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_data = 8'h00; pcm_valid = 1'b0; pcm_data = 16'h0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_flush", fifo_flush, 0);
    chk("rst_mic_en", mic_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_status", status, 8'h00);

    // Fixed-length capture of 3 samples after 4 warm-up samples
    cmd(8'hA1); cmd(8'h00); cmd(8'h03);
    chk("t1_mic_en_warm", mic_en, 1);
    chk("t1_status_warm", status, 8'h90);
    for (int k = 1; k <= 7; k++) begin
      pcm(16'(k));
      idle(3);
      if (k == 4) chk("t1_no_bytes_in_warmup", wlog.size(), 0);
      if (k == 5) chk("t1_status_capture", status, 8'hA0);
    end
    idle(2);
    chk("t1_nbytes", wlog.size(), 6);
    if (wlog.size() == 6) begin
      chk("t1_b0", wlog[0], 8'h00); chk("t1_b1", wlog[1], 8'h05);
      chk("t1_b2", wlog[2], 8'h00); chk("t1_b3", wlog[3], 8'h06);
      chk("t1_b4", wlog[4], 8'h00); chk("t1_b5", wlog[5], 8'h07);
    end
    chk("t1_mic_en_done", mic_en, 0);
    chk("t1_status_done", status, 8'h38);

    // LSB held by fifo_full, second sample dropped as overflow
    wlog.delete(); wcyc.delete();
    cmd(8'hA1); cmd(8'h00); cmd(8'h02);
    chk("t2_status_start", status, 8'h90);
    warmup();
    t0 = cnum;
    pcm(16'h1234);
    cyc(1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    idle(2);
    chk("t2_nbytes_pair", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t2_msb", wlog[0], 8'h12);
      chk("t2_lsb", wlog[1], 8'h34);
      chk("t2_msb_cycle", wcyc[0] - t0, 1);
      chk("t2_lsb_cycle", wcyc[1] - t0, 5);
    end
    chk("t2_overflow", overflow, 1);
    pcm(16'h5678);
    idle(5);
    chk("t2_nbytes", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("t2_b2", wlog[2], 8'h56);
      chk("t2_b3", wlog[3], 8'h78);
    end
    chk("t2_status_done_ovf", status, 8'h78);

    // CLEAR in DONE with overflow set
    fl0 = nflush;
    cmd(8'hA3);
    chk("t4_flush_pulse", fifo_flush, 1);
    idle(1);
    chk("t4_flush_one_cycle", fifo_flush, 0);
    chk("t4_flush_count", nflush - fl0, 1);
    chk("t4_overflow_cleared", overflow, 0);
    chk("t4_status_cleared", status, 8'h00);

    // Continuous capture, CLEAR while busy, STOP with LSB pending
    wlog.delete(); wcyc.delete();
    cmd(8'hA1); cmd(8'h00); cmd(8'h00);
    warmup();
    for (int i = 0; i < 9; i++) begin
      pcm({8'h10 + 8'(i), 8'h20 + 8'(i)});
      idle(3);
      if (i == 4) begin
        fl0 = nflush;
        cmd(8'hA3);
        idle(2);
        chk("t3_clear_busy_noflush", nflush - fl0, 0);
        chk("t3_status_busy", status, 8'hA0);
      end
    end
    pcm(16'h1929);
    cyc(1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 16'h0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    idle(4);
    chk("t3_nbytes", wlog.size(), 20);
    if (wlog.size() == 20) begin
      for (int i = 0; i < 10; i++) begin
        chk("t3_msb", wlog[2*i], 32'(8'h10 + 8'(i)));
        chk("t3_lsb", wlog[2*i+1], 32'(8'h20 + 8'(i)));
      end
    end
    chk("t3_status_idle", status, 8'h00);
    chk("t3_mic_en_off", mic_en, 0);

    // Unknown opcode ignored, then a normal 2-sample capture
    wlog.delete(); wcyc.delete();
    cmd(8'h55);
    chk("t5_status_after_55", status, 8'h00);
    cmd(8'hA1); cmd(8'h00); cmd(8'h02);
    chk("t5_status_start", status, 8'h90);
    warmup();
    pcm(16'hA55A); idle(3);
    pcm(16'h0FF0); idle(5);
    nb = wlog.size();
    chk("t5_nbytes", nb, 4);
    if (nb == 4) begin
      chk("t5_b0", wlog[0], 8'hA5); chk("t5_b1", wlog[1], 8'h5A);
      chk("t5_b2", wlog[2], 8'h0F); chk("t5_b3", wlog[3], 8'hF0);
    end
    chk("t5_status_done", status, 8'h38);

    // Reset mid-capture with the LSB pending
    wlog.delete(); wcyc.delete();
    cmd(8'hA1); cmd(8'h00); cmd(8'h05);
    warmup();
    pcm(16'hCAFE);
    cyc(1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
    rst = 1'b0;
    fifo_full = 1'b0;
    #1;
    chk("t6_wr_en", fifo_wr_en, 0);
    chk("t6_status", status, 8'h00);
    chk("t6_mic_en", mic_en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_flush", fifo_flush, 0);
    idle(4);
    chk("t6_nbytes", wlog.size(), 1);
    if (wlog.size() == 1) chk("t6_b0", wlog[0], 8'hCA);
    wlog.delete();
    cmd(8'hA1); cmd(8'h00); cmd(8'h01);
    warmup();
    pcm(16'h0BAD); idle(5);
    chk("t6_post_nbytes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t6_post_b0", wlog[0], 8'h0B);
      chk("t6_post_b1", wlog[1], 8'hAD);
    end
    chk("t6_post_status", status, 8'h38);

    chk("wr_while_full", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
